lab3_cache_cache_mem_sender: RTL and testbench

//  Serializes one cache-line transaction into p_num_words 4B memory requests.

---
 rtl/lab3_cache_cache_mem_sender_if.sv | 56 +++++
 rtl/lab3_cache_cache_mem_sender.sv | 89 ++++++++
 tb/tb_lab3_cache_cache_mem_sender.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lab3_cache_cache_mem_sender_if.sv
// Shared types and the line/memory handshake bundle between the cache and the
// word sender. The package holds the 4B memory request format and the FSM state type.
package lab3_cache_cache_mem_sender_pkg;

  localparam logic [2:0] VC_MEM_REQ_MSG_TYPE_READ  = 3'd0;
  localparam logic [2:0] VC_MEM_REQ_MSG_TYPE_WRITE = 3'd1;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_RESP = 2'd2
  } state_t;

endpackage

// Handshakes: a transfer happens on a rising clk edge where val && rdy are both
// high; a producer holding val keeps its payload stable until that edge.
interface lab3_cache_cache_mem_sender_if #(
  parameter int p_num_words = 16
);
  import lab3_cache_cache_mem_sender_pkg::*;

  logic                     line_val;
  logic                     line_rdy;
  logic                     line_is_wr;
  logic [31:0]              line_addr;
  logic [32*p_num_words-1:0] line_data;

  logic                     mem_req_val;
  logic                     mem_req_rdy;
  mem_req_4B_t              mem_req_msg;

  logic                     start_receive;
  logic                     recv_done;

  state_t                   dbg_state;

  modport master (
    input  line_val, line_is_wr, line_addr, line_data, mem_req_rdy, recv_done,
    output line_rdy, mem_req_val, mem_req_msg, start_receive, dbg_state
  );

  modport slave (
    output line_val, line_is_wr, line_addr, line_data, mem_req_rdy, recv_done,
    input  line_rdy, mem_req_val, mem_req_msg, start_receive, dbg_state
  );

endinterface

// File: rtl/lab3_cache_cache_mem_sender.sv
// Serializes one cache-line refill or writeback into p_num_words 4-byte memory
// requests, and flags the downstream receiver while a read burst is outstanding.
module lab3_cache_cache_mem_sender
  import lab3_cache_cache_mem_sender_pkg::*;
#(
  parameter int p_num_words = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  lab3_cache_cache_mem_sender_if.master bus
);

  localparam int CW = $clog2(p_num_words);
  localparam int OW = $clog2(4 * p_num_words);
  localparam logic [CW-1:0] LAST      = CW'(p_num_words - 1);
  localparam logic [31:0]   ADDR_MASK = ~(32'((1 << OW) - 1));

  state_t                    state;
  state_t                    state_nxt;
  logic [CW-1:0]             cnt;
  logic                      is_wr_q;
  logic [31:0]               addr_q;
  logic [32*p_num_words-1:0] data_q;

  logic line_fire;
  logic req_fire;
  logic req_last;

  assign line_fire = bus.line_val && bus.line_rdy;
  assign req_fire  = bus.mem_req_val && bus.mem_req_rdy;
  assign req_last  = (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      is_wr_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state <= state_nxt;
      if (line_fire) begin
        is_wr_q <= bus.line_is_wr;
        addr_q  <= bus.line_addr & ADDR_MASK;
        data_q  <= bus.line_data;
        cnt     <= '0;
      end else if (req_fire) begin
        cnt <= req_last ? '0 : cnt + 1'b1;
      end
    end
  end

  // Outputs are qualified with reset so nothing is asserted while reset is low,
  // even though the state register already sits in IDLE.
  always_comb begin
    state_nxt             = state;
    bus.line_rdy          = 1'b0;
    bus.mem_req_val       = 1'b0;
    bus.start_receive     = 1'b0;
    bus.mem_req_msg       = '0;
    bus.dbg_state         = state;

    case (state)
      IDLE: begin
        bus.line_rdy = reset;
        if (bus.line_val) state_nxt = SEND;
      end
      SEND: begin
        bus.mem_req_val       = reset;
        bus.start_receive     = reset && !is_wr_q;
        bus.mem_req_msg.type_ = is_wr_q ? VC_MEM_REQ_MSG_TYPE_WRITE
                                        : VC_MEM_REQ_MSG_TYPE_READ;
        bus.mem_req_msg.opaque = {{(8-CW){1'b0}}, cnt};
        bus.mem_req_msg.addr   = addr_q + {{(30-CW){1'b0}}, cnt, 2'b00};
        bus.mem_req_msg.len    = 2'd0;
        bus.mem_req_msg.data   = is_wr_q ? data_q[{cnt, 5'b00000} +: 32] : 32'b0;
        if (bus.mem_req_rdy && req_last) state_nxt = is_wr_q ? IDLE : WAIT_RESP;
      end
      WAIT_RESP: begin
        bus.start_receive = reset;
        if (bus.recv_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (!reset) bus.mem_req_msg = '0;
  end

endmodule

// File: tb/tb_lab3_cache_cache_mem_sender.sv
// Randomized self-checking bench for the cache line-to-word sender: each burst is
// collected from the bus and compared against a per-line list of expected requests.
module tb_lab3_cache_cache_mem_sender;
  import lab3_cache_cache_mem_sender_pkg::*;

  localparam int N = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  lab3_cache_cache_mem_sender_if #(.p_num_words(N)) bus ();

  lab3_cache_cache_mem_sender #(.p_num_words(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests_run = 0;
  int tests_failed = 0;

  mem_req_4B_t exp_q[$];
  mem_req_4B_t obs_q[$];
  int c_stall, c_sr, c_proto;
  bit c_first, c_timeout;

  // Reference: a line becomes N word requests at aligned base + 4*i.
  function automatic void build_exp(input bit wr, input logic [31:0] a,
                                    input logic [32*N-1:0] d);
    logic [31:0] base;
    mem_req_4B_t m;
    base = a - (a % (4 * N));
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      m.type_  = wr ? VC_MEM_REQ_MSG_TYPE_WRITE : VC_MEM_REQ_MSG_TYPE_READ;
      m.opaque = 8'(i);
      m.addr   = base + 32'(4 * i);
      m.len    = 2'd0;
      m.data   = wr ? d[32*i +: 32] : 32'd0;
      exp_q.push_back(m);
    end
  endfunction

  function automatic logic [32*N-1:0] rand_line();
    logic [32*N-1:0] d;
    for (int i = 0; i < N; i++) d[32*i +: 32] = $urandom();
    return d;
  endfunction

  task automatic send_line(input bit wr, input logic [31:0] a,
                           input logic [32*N-1:0] d, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    bus.line_val   = 1'b1;
    bus.line_is_wr = wr;
    bus.line_addr  = a;
    bus.line_data  = d;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.line_rdy === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end
    bus.line_val = 1'b0;
  endtask

  // Drives mem_req_rdy (0: always, 1: one cycle in three, else random) and
  // records every accepted request; stops just before the n-th handshake edge.
  task automatic collect(input int n, input int mode, input bit exp_sr,
                         input bit pulse_done);
    int got;
    int cyc;
    bit prev_stall;
    mem_req_4B_t prev_msg;
    got = 0; cyc = 0; prev_stall = 1'b0; prev_msg = '0;
    obs_q.delete();
    c_stall = 0; c_sr = 0; c_proto = 0; c_first = 1'b0; c_timeout = 1'b0;
    while (got < n && cyc < 2000) begin
      @(negedge clk);
      case (mode)
        0:       bus.mem_req_rdy = 1'b1;
        1:       bus.mem_req_rdy = (cyc % 3 == 2);
        default: bus.mem_req_rdy = 1'($urandom_range(0, 1));
      endcase
      if (pulse_done) bus.recv_done = 1'($urandom_range(0, 1));
      #1;
      if (cyc == 0) c_first = (bus.mem_req_val === 1'b1);
      if (bus.mem_req_val === 1'b1) begin
        if (prev_stall && bus.mem_req_msg !== prev_msg) c_stall++;
        if (bus.start_receive !== exp_sr) c_sr++;
        if (bus.line_rdy !== 1'b0) c_proto++;
        if (bus.mem_req_rdy) begin
          obs_q.push_back(bus.mem_req_msg);
          got++;
        end
        prev_stall = !bus.mem_req_rdy;
        prev_msg   = bus.mem_req_msg;
      end else begin
        c_proto++;
      end
      cyc++;
    end
    c_timeout = (got < n);
    bus.recv_done = 1'b0;
  endtask

  // Holds off recv_done for a few cycles in the response wait, then pulses it.
  task automatic finish_read(output int errs);
    int k;
    errs = 0;
    k = $urandom_range(1, 4);
    repeat (k) begin
      @(negedge clk);
      #1;
      if (bus.mem_req_val !== 1'b0 || bus.start_receive !== 1'b1 ||
          bus.line_rdy !== 1'b0) errs++;
    end
    bus.recv_done = 1'b1;
    @(negedge clk);
    bus.recv_done = 1'b0;
    #1;
    if (bus.line_rdy !== 1'b1 || bus.start_receive !== 1'b0 ||
        bus.mem_req_val !== 1'b0) errs++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.line_val = 1'b1; bus.line_is_wr = 1'b1;
    bus.line_addr = $urandom(); bus.line_data = rand_line();
    bus.mem_req_rdy = 1'b1; bus.recv_done = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if (bus.line_rdy !== 1'b0) begin tests_failed++; $display("FAIL reset_line_rdy: got %b want 0", bus.line_rdy); end
    tests_run++;
    if (bus.mem_req_val !== 1'b0) begin tests_failed++; $display("FAIL reset_req_val: got %b want 0", bus.mem_req_val); end
    tests_run++;
    if (bus.start_receive !== 1'b0) begin tests_failed++; $display("FAIL reset_start_receive: got %b want 0", bus.start_receive); end
    tests_run++;
    if (bus.mem_req_msg !== '0) begin tests_failed++; $display("FAIL reset_msg: got %h want 0", bus.mem_req_msg); end
    bus.line_val = 1'b0; bus.recv_done = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    tests_run++;
    if (bus.line_rdy !== 1'b1) begin tests_failed++; $display("FAIL post_reset_line_rdy: got %b want 1", bus.line_rdy); end
    tests_run++;
    if (bus.dbg_state !== IDLE) begin tests_failed++; $display("FAIL post_reset_state: got %0d want %0d", bus.dbg_state, IDLE); end
  endtask

  task automatic test_line(input string name, input bit wr, input logic [31:0] a,
                           input logic [32*N-1:0] d, input int mode);
    bit ok;
    int errs;
    build_exp(wr, a, d);
    send_line(wr, a, d, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL %s accept: line_rdy never seen", name); end
    collect(N, mode, !wr, 1'b0);
    tests_run++;
    if (!c_first || c_timeout) begin tests_failed++; $display("FAIL %s timing: first_val=%b timeout=%b want 1/0", name, c_first, c_timeout); end
    tests_run++;
    if (c_stall + c_sr + c_proto != 0) begin tests_failed++; $display("FAIL %s protocol: stall=%0d start_receive=%0d other=%0d want 0", name, c_stall, c_sr, c_proto); end
    tests_run++;
    if (obs_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL %s count: got %0d want %0d", name, obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      tests_run++;
      if (obs_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL %s req%0d: got %h want %h", name, i, obs_q[i], exp_q[i]); end
    end
    if (wr) begin
      @(negedge clk);
      #1;
      errs = (bus.line_rdy !== 1'b1 || bus.mem_req_val !== 1'b0 || bus.start_receive !== 1'b0) ? 1 : 0;
    end else begin
      finish_read(errs);
    end
    tests_run++;
    if (errs != 0) begin tests_failed++; $display("FAIL %s end_of_burst: got %0d errors want 0", name, errs); end
  endtask

  task automatic test_read();
    test_line("read", 1'b0, 32'h0000_1000, '0, 0);
  endtask

  task automatic test_write();
    logic [32*N-1:0] d;
    for (int i = 0; i < N; i++) d[32*i +: 32] = 32'hA000_0000 + 32'(i);
    test_line("write", 1'b1, 32'h0000_2040, d, 0);
  endtask

  task automatic test_backpressure();
    test_line("bp_read", 1'b0, 32'h0000_4000, '0, 1);
    test_line("bp_write", 1'b1, $urandom(), rand_line(), 1);
  endtask

  task automatic test_unaligned();
    test_line("unaligned", 1'b0, 32'h0000_1234, '0, 0);
    tests_run++;
    if (exp_q[0].addr !== 32'h0000_1200 || exp_q[N-1].addr !== 32'h0000_123C) begin
      tests_failed++; $display("FAIL unaligned_model: got %h..%h want 00001200..0000123c", exp_q[0].addr, exp_q[N-1].addr);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int errs;
    build_exp(1'b0, 32'h0000_5000, '0);
    send_line(1'b0, 32'h0000_5000, '0, ok);
    collect(5, 0, 1'b1, 1'b0);
    tests_run++;
    if (!ok || c_timeout || obs_q.size() != 5) begin tests_failed++; $display("FAIL rst_mid_prefix: got %0d reqs want 5", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < 5; i++) begin
      tests_run++;
      if (obs_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL rst_mid_req%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests_run++;
    if (bus.mem_req_val !== 1'b0 || bus.start_receive !== 1'b0 || bus.line_rdy !== 1'b0) begin
      tests_failed++; $display("FAIL rst_mid_outputs: got val=%b sr=%b rdy=%b want 0/0/0", bus.mem_req_val, bus.start_receive, bus.line_rdy);
    end
    errs = 0;
    repeat (3) begin
      @(negedge clk);
      #1;
      if (bus.mem_req_val !== 1'b0 || bus.mem_req_msg !== '0) errs++;
    end
    tests_run++;
    if (errs != 0) begin tests_failed++; $display("FAIL rst_mid_hold: got %0d cycles with activity want 0", errs); end
    @(negedge clk);
    reset = 1'b1;
    test_line("rst_restart", 1'b0, 32'h0000_3000, '0, 0);
  endtask

  task automatic test_protocol();
    bit ok;
    int errs;
    logic [32*N-1:0] da;
    logic [31:0] ab;
    @(negedge clk);
    bus.recv_done = 1'b1;
    @(negedge clk);
    bus.recv_done = 1'b0;
    #1;
    tests_run++;
    if (bus.line_rdy !== 1'b1 || bus.mem_req_val !== 1'b0 || bus.start_receive !== 1'b0 || bus.dbg_state !== IDLE) begin
      tests_failed++; $display("FAIL proto_idle_done: got rdy=%b val=%b sr=%b want 1/0/0", bus.line_rdy, bus.mem_req_val, bus.start_receive);
    end
    da = rand_line();
    build_exp(1'b1, 32'h0000_6000, da);
    send_line(1'b1, 32'h0000_6000, da, ok);
    ab = $urandom();
    bus.line_val = 1'b1; bus.line_is_wr = 1'b0; bus.line_addr = ab; bus.line_data = rand_line();
    collect(N, 2, 1'b0, 1'b1);
    tests_run++;
    if (!ok || c_timeout || c_stall + c_sr + c_proto != 0) begin
      tests_failed++; $display("FAIL proto_held_burst: timeout=%b stall=%0d sr=%0d other=%0d want 0", c_timeout, c_stall, c_sr, c_proto);
    end
    tests_run++;
    if (obs_q.size() != N) begin tests_failed++; $display("FAIL proto_held_count: got %0d want %0d", obs_q.size(), N); end
    for (int i = 0; i < obs_q.size() && i < N; i++) begin
      tests_run++;
      if (obs_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL proto_held_req%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (bus.line_rdy !== 1'b1 || bus.mem_req_val !== 1'b0) begin
      tests_failed++; $display("FAIL proto_back_idle: got rdy=%b val=%b want 1/0", bus.line_rdy, bus.mem_req_val);
    end
    @(posedge clk);
    #1;
    bus.line_val = 1'b0;
    build_exp(1'b0, ab, '0);
    collect(N, 0, 1'b1, 1'b0);
    tests_run++;
    if (!c_first || c_timeout || obs_q.size() != N) begin
      tests_failed++; $display("FAIL proto_second_line: first=%b got %0d reqs want 1/%0d", c_first, obs_q.size(), N);
    end
    for (int i = 0; i < obs_q.size() && i < N; i++) begin
      tests_run++;
      if (obs_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL proto_second_req%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    finish_read(errs);
    tests_run++;
    if (errs != 0) begin tests_failed++; $display("FAIL proto_second_end: got %0d errors want 0", errs); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      test_line($sformatf("rand%0d", t), 1'($urandom_range(0, 1)), $urandom(), rand_line(), 2);
    end
  endtask

  initial begin
    bus.line_val = 1'b0; bus.line_is_wr = 1'b0; bus.line_addr = '0; bus.line_data = '0;
    bus.mem_req_rdy = 1'b0; bus.recv_done = 1'b0;
    test_reset();
    test_read();
    test_write();
    test_backpressure();
    test_unaligned();
    test_reset_mid();
    test_protocol();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
